// File: rtl/detect_pkg.sv
// -----------------------------------------------------------------------------
// detect_pkg
// Shared definitions for the detection event logger:
//   - default timestamp / sequence widths
//   - record width helper and default record width
//   - occupancy FSM state encoding used by the event FIFO
// -----------------------------------------------------------------------------
package detect_pkg;

  // Default widths for the free-running timestamp and the sequence/drop counters.
  localparam int DEF_TS_W  = 16;
  localparam int DEF_SEQ_W = 8;

  // A record is {timestamp, sequence number}.
  localparam int REC_W = DEF_TS_W + DEF_SEQ_W;

  function automatic int rec_w(input int ts_w, input int seq_w);
    return ts_w + seq_w;
  endfunction

  // Occupancy state of the event FIFO.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

endpackage : detect_pkg

// File: rtl/detect_event_logger_fifo.sv
// -----------------------------------------------------------------------------
// event_fifo
// Show-ahead FIFO with a registered head record and an occupancy FSM
// (EMPTY / PARTIAL / FULL). Pointers carry one extra wrap bit so the
// occupancy is simply wr_ptr - rd_ptr.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   clear_i    in   synchronous flush (dominates push/pop)
//   push_i     in   write wr_data_i this cycle (caller guarantees !full || pop)
//   pop_i      in   consume the head record this cycle (caller guarantees !empty)
//   wr_data_i  in   record to write
//   head_o     out  registered head record (valid while !empty_o)
//   full_o     out  FIFO holds DEPTH records
//   empty_o    out  FIFO holds no records
// -----------------------------------------------------------------------------
module event_fifo
  import detect_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   rd_next;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] head_q, head_d;
  fifo_state_e      state_q, state_d;

  logic do_push;
  logic do_pop;

  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i  && !clear_i;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_next = rd_ptr_q + PTR_ONE;

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (do_push) state_d = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (do_push && !do_pop && count == CNT_LAST) begin
            state_d = ST_FULL;
          end else if (do_pop && !do_push && count == PTR_ONE) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (do_pop && !do_push) state_d = ST_PARTIAL;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    empty_o = (state_q == ST_EMPTY);
    full_o  = (state_q == ST_FULL);
  end

  // ---------------------------------------------------------------------------
  // Pointer and head-record next-state
  // The head register always holds the record at rd_ptr, so after a pop it is
  // reloaded from the following slot -- or straight from wr_data_i when that
  // slot is being written in this very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      head_d   = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop) begin
        rd_ptr_d = rd_next;
        if (rd_next != wr_ptr_q) begin
          head_d = mem_q[rd_next[PTR_W-1:0]];
        end else if (do_push) begin
          head_d = wr_data_i;
        end
      end else if (do_push && state_q == ST_EMPTY) begin
        head_d = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

  // NOTE: the storage array has no reset; a slot is only ever read after it
  // has been written, and the visible head comes from the reset head register.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
  end

  assign head_o = head_q;

endmodule : event_fifo

// File: rtl/detect_event_logger.sv
// -----------------------------------------------------------------------------
// detect_event_logger
// Stamps each detection pulse with a free-running cycle count and a sequence
// number, queues it in a small FIFO and presents it to a reader over
// valid/ready. Events that arrive while the FIFO is full (and not being
// popped) are dropped, counted in a saturating drop counter and flagged by a
// sticky overflow bit. Dropped events still consume a sequence number, so the
// reader sees a gap in ev_seq.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   det_pulse  in   detection pulse; every high cycle is one event
//   clear      in   synchronous soft clear (FIFO, counters, flags)
//   ev_valid   out  head record available
//   ev_ready   in   reader accepts head record when ev_valid && ev_ready
//   ev_ts      out  timestamp of head record
//   ev_seq     out  sequence number of head record
//   drop_cnt   out  saturating count of dropped events
//   overflow   out  sticky, set on the first drop
// -----------------------------------------------------------------------------
module detect_event_logger
  import detect_pkg::*;
#(
  parameter int TS_W  = DEF_TS_W,
  parameter int SEQ_W = DEF_SEQ_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_pulse,
  input  logic             clear,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic [SEQ_W-1:0] ev_seq,
  output logic [SEQ_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam int REC_BITS = rec_w(TS_W, SEQ_W);

  logic [TS_W-1:0]     ts_ctr_q,   ts_ctr_d;
  logic [SEQ_W-1:0]    seq_ctr_q,  seq_ctr_d;
  logic [SEQ_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                overflow_q, overflow_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic [REC_BITS-1:0] head_rec;
  logic [REC_BITS-1:0] new_rec;

  logic                pop;
  logic                push;
  logic                drop;

  // A pop frees the slot in the same cycle, so a pulse into a full FIFO is
  // still accepted when the reader takes the head record at the same time.
  assign pop     = ev_valid && ev_ready && !clear;
  assign push    = det_pulse && !clear && (!fifo_full || pop);
  assign drop    = det_pulse && !clear && fifo_full && !pop;
  assign new_rec = {ts_ctr_q, seq_ctr_q};

  always_comb begin
    ts_ctr_d   = ts_ctr_q + TS_W'(1);
    seq_ctr_d  = seq_ctr_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clear) begin
      ts_ctr_d   = '0;
      seq_ctr_d  = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (det_pulse) seq_ctr_d = seq_ctr_q + SEQ_W'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + SEQ_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_ctr_q   <= '0;
      seq_ctr_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_ctr_q   <= ts_ctr_d;
      seq_ctr_q  <= seq_ctr_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (REC_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (new_rec),
    .head_o    (head_rec),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_ts    = head_rec[REC_BITS-1:SEQ_W];
  assign ev_seq   = head_rec[SEQ_W-1:0];
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule : detect_event_logger

// File: tb/tb_detect_event_logger.sv
// -----------------------------------------------------------------------------
// tb_detect_event_logger
// Small widths (TS_W=4, SEQ_W=4) so wrap and saturation are reached quickly.
// A queue-based model tracks the records the reader should see; a negedge
// process compares every output against it each cycle. Directed scenarios add
// literal expectations, then a randomized run exercises the general case.
// -----------------------------------------------------------------------------
module tb_detect_event_logger;

  localparam int TS_W    = 4;
  localparam int SEQ_W   = 4;
  localparam int DEPTH   = 4;
  localparam int TS_MOD  = 1 << TS_W;
  localparam int SEQ_MOD = 1 << SEQ_W;
  localparam int SAT     = SEQ_MOD - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             det_pulse;
  logic             clear;
  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W-1:0]  ev_ts;
  logic [SEQ_W-1:0] ev_seq;
  logic [SEQ_W-1:0] drop_cnt;
  logic             overflow;

  detect_event_logger #(
    .TS_W  (TS_W),
    .SEQ_W (SEQ_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .det_pulse (det_pulse),
    .clear     (clear),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_ts     (ev_ts),
    .ev_seq    (ev_seq),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    int ts;
    int seq;
  } rec_t;

  rec_t m_q[$];
  int   m_ts;
  int   m_seq;
  int   m_drop;
  bit   m_ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ts   = 0;
    m_seq  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge(input bit det, input bit rdy, input bit clr);
    bit was_full;
    bit pop;
    if (clr) begin
      model_reset();
      return;
    end
    was_full = (m_q.size() == DEPTH);
    pop      = (m_q.size() != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (det) begin
      if (!was_full || pop) begin
        m_q.push_back('{ts: m_ts, seq: m_seq});
      end else begin
        m_ovf = 1'b1;
        if (m_drop < SAT) m_drop++;
      end
      m_seq = (m_seq + 1) % SEQ_MOD;
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_valid", int'(ev_valid), (m_q.size() != 0) ? 1 : 0);
      if (m_q.size() != 0) begin
        check("cmp_ts",  int'(ev_ts),  m_q[0].ts);
        check("cmp_seq", int'(ev_seq), m_q[0].seq);
      end
      check("cmp_drop", int'(drop_cnt), m_drop);
      check("cmp_ovf",  int'(overflow), int'(m_ovf));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit det, input bit rdy, input bit clr);
    det_pulse = det;
    ev_ready  = rdy;
    clear     = clr;
    @(posedge clk);
    model_edge(det, rdy, clr);
    cyc++;
    #1;
  endtask

  task automatic idle_until(input int t, input bit rdy);
    while (cyc < t) step(1'b0, rdy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(ev_valid), 0);
    check({tag, "_ts"},    int'(ev_ts),    0);
    check({tag, "_seq"},   int'(ev_seq),   0);
    check({tag, "_drop"},  int'(drop_cnt), 0);
    check({tag, "_ovf"},   int'(overflow), 0);
  endtask

  // Called 1 unit after a rising edge; reset is pulsed well clear of any edge.
  task automatic async_reset(input string tag);
    det_pulse = 1'b0;
    ev_ready  = 1'b0;
    clear     = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    #1 check_zero(tag);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  int exp_seq [4] = '{1, 2, 3, 6};
  int exp_ts  [4] = '{5, 6, 7, 10};

  initial begin
    rst       = 1'b1;
    det_pulse = 1'b0;
    ev_ready  = 1'b0;
    clear     = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 check_zero("reset");
    #1 rst = 1'b0;
    cyc    = 0;
    chk_on = 1'b1;

    // Single event at cycle 10, reader always ready.
    idle_until(10, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("single_valid", int'(ev_valid), 1);
    check("single_ts",    int'(ev_ts),    10);
    check("single_seq",   int'(ev_seq),   0);
    step(1'b0, 1'b1, 1'b0);
    check("single_gone",  int'(ev_valid), 0);

    // Backpressure overflow: 6 pulses at cycles 20..25 into a 4-deep FIFO.
    async_reset("rst1");
    idle_until(20, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    check("ovf_drop",  int'(drop_cnt), 2);
    check("ovf_flag",  int'(overflow), 1);
    check("ovf_head_ts",  int'(ev_ts),  4);
    check("ovf_head_seq", int'(ev_seq), 0);

    // Full FIFO with push and pop in the same cycle: no drop.
    step(1'b1, 1'b1, 1'b0);
    check("pp_drop",  int'(drop_cnt), 2);
    check("pp_valid", int'(ev_valid), 1);
    for (int i = 0; i < 4; i++) begin
      check("drain_seq", int'(ev_seq), exp_seq[i]);
      check("drain_ts",  int'(ev_ts),  exp_ts[i]);
      step(1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", int'(ev_valid), 0);

    // Timestamp wrap, then drop-counter saturation.
    async_reset("rst2");
    idle_until(17, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("wrap_ts",  int'(ev_ts),  1);
    check("wrap_seq", int'(ev_seq), 0);
    for (int i = 0; i < 3 + 20; i++) step(1'b1, 1'b0, 1'b0);
    check("sat_drop", int'(drop_cnt), 15);
    check("sat_ovf",  int'(overflow), 1);

    // Clear with three records held and a pulse in the clear cycle.
    async_reset("rst3");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("clr_pre_valid", int'(ev_valid), 1);
    step(1'b1, 1'b1, 1'b1);
    check("clr_valid", int'(ev_valid), 0);
    check("clr_drop",  int'(drop_cnt), 0);
    check("clr_ovf",   int'(overflow), 0);
    step(1'b1, 1'b0, 1'b0);
    check("clr_next_seq", int'(ev_seq), 0);
    check("clr_next_ts",  int'(ev_ts),  0);

    // Async reset while a record is being presented.
    check("arst_pre_valid", int'(ev_valid), 1);
    async_reset("arst");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_detect_event_logger
